// File: rtl/strength_resolved_bus.sv
// Multi-channel shared bus resolved by drive strength: a granted channel drives strong,
// force drivers and the idle pull act at pull strength; round-robin owner with minimum hold.
module strength_resolved_bus #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned PULL_HIGH   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS-1:0]          req,
  input  logic [CHANNELS*WIDTH-1:0]    data,
  input  logic [CHANNELS-1:0]          force_en,
  output logic [CHANNELS-1:0]          grant,
  output logic [$clog2(CHANNELS)-1:0]  owner,
  output logic [WIDTH-1:0]             bus,
  output logic [WIDTH-1:0]             bus_q,
  output logic                         valid,
  output logic [15:0]                  contention_cnt
);

  localparam int unsigned OW = $clog2(CHANNELS);
  localparam int unsigned HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [WIDTH-1:0] PULL_VEC = (PULL_HIGH != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       ptr_q, ptr_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic                valid_q;
  logic [15:0]         cnt_q;
  logic                rearb;
  logic [OW-1:0]       arb_ptr;
  logic                contend;
  logic [WIDTH-1:0]    own_val, drv0, drv1;

  // First requester at or after ptr, searching circularly.
  function automatic logic [OW-1:0] rr_pick(input logic [CHANNELS-1:0] r,
                                            input logic [OW-1:0] ptr);
    logic [OW-1:0] sel;
    logic          found;
    int unsigned   idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      idx = (32'(ptr) + k) % CHANNELS;
      if (!found && r[OW'(idx)]) begin
        found = 1'b1;
        sel   = OW'(idx);
      end
    end
    return sel;
  endfunction

  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] o);
    if (32'(o) == CHANNELS - 1) return '0;
    return o + OW'(1);
  endfunction

  // Next-state: hold the owner until its hold expires or it drops req, then rotate.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    rearb   = 1'b0;
    arb_ptr = ptr_q;
    case (state_q)
      IDLE: begin
        if (|req) rearb = 1'b1;
      end
      GRANT: begin
        if (req[owner_q] && (hold_q != '0)) begin
          hold_d = hold_q - HW'(1);
        end else begin
          ptr_d   = next_idx(owner_q);
          arb_ptr = next_idx(owner_q);
          if (|req) begin
            rearb = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            owner_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rearb) begin
      owner_d = rr_pick(req, arb_ptr);
      grant_d = CHANNELS'(1) << owner_d;
      hold_d  = HOLD_LOAD;
      state_d = GRANT;
    end
  end

  // Strength resolution: strong owner wins; otherwise pull-strength drivers must agree or give X.
  always_comb begin
    own_val = '0;
    drv1    = PULL_VEC;
    drv0    = ~PULL_VEC;
    bus     = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant_q[i]) own_val = own_val | data[i*WIDTH +: WIDTH];
      if (force_en[i]) begin
        drv1 = drv1 | data[i*WIDTH +: WIDTH];
        drv0 = drv0 | ~data[i*WIDTH +: WIDTH];
      end
    end
    for (int unsigned b = 0; b < WIDTH; b++) begin
      if (|grant_q)              bus[b] = own_val[b];
      else if (drv0[b] && drv1[b]) bus[b] = 1'bx;
      else                       bus[b] = drv1[b];
    end
  end

  assign contend = (|force_en) && ((|grant_q) || ($countones(force_en) > 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      bus_q   <= PULL_VEC;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      bus_q   <= bus;
      valid_q <= |grant_q;
      if (contend && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign grant          = grant_q;
  assign owner          = owner_q;
  assign valid          = valid_q;
  assign contention_cnt = cnt_q;

endmodule
